gt_frame_gen: RTL and testbench

//  Parametrised transmit test-pattern generator for the GTP link. Emits 8b/10b-ready words

---
 rtl/gt_frame_gen_if.sv | 30 +++
 rtl/gt_frame_gen.sv | 156 +++++++++++++++
 tb/tb_gt_frame_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gt_frame_gen_if.sv
// Handshake/bus bundle between the link control logic (master) and the
// transmit test-pattern generator (slave).
interface gt_frame_gen_if #(
    parameter int BYTES = 2,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = 8 * BYTES;

    logic            ready;
    logic            enable;
    logic [1:0]      mode;
    logic            tbl_we;
    logic [AW-1:0]   tbl_addr;
    logic [W-1:0]    tbl_wdata;
    logic [W-1:0]    tx_data;
    logic [BYTES-1:0] tx_charisk;
    logic            frame_start;
    logic [15:0]     frame_cnt;

    modport master (
        output ready, enable, mode, tbl_we, tbl_addr, tbl_wdata,
        input  tx_data, tx_charisk, frame_start, frame_cnt
    );

    modport slave (
        input  ready, enable, mode, tbl_we, tbl_addr, tbl_wdata,
        output tx_data, tx_charisk, frame_start, frame_cnt
    );
endinterface

// File: rtl/gt_frame_gen.sv
// Transmit test-pattern generator for the GTP link. Each frame is one all-K28.5
// comma word followed by COMMA_PERIOD-1 payload words taken from a loadable
// table, an incrementing counter or a PRBS-7 sequence. Every output is a flop.
module gt_frame_gen #(
    parameter int          BYTES        = 2,
    parameter int          DEPTH        = 8,
    parameter int          COMMA_PERIOD = 4,
    parameter logic [7:0]  K_CHAR       = 8'hBC
) (
    input  logic          tx_clk,
    input  logic          reset_n,
    gt_frame_gen_if.slave bus
);
    localparam int W      = 8 * BYTES;
    localparam int AW     = $clog2(DEPTH);
    localparam int SLOT_W = $clog2(COMMA_PERIOD);

    localparam logic [W-1:0]      COMMA_WORD = {BYTES{K_CHAR}};
    localparam logic [BYTES-1:0]  K_ALL      = {BYTES{1'b1}};
    localparam logic [6:0]        LFSR_SEED  = 7'h7F;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(COMMA_PERIOD - 1);

    localparam logic [1:0] MODE_COMMA = 2'd0;
    localparam logic [1:0] MODE_TABLE = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [1:0] MODE_PRBS  = 2'd3;

    // Pattern table: not reset, contents survive reset and ready drops.
    logic [W-1:0] tbl_mem_q [DEPTH];

    logic [SLOT_W-1:0] slot_q,        slot_d;
    logic [AW-1:0]     ptr_q,         ptr_d;
    logic [W-1:0]      counter_q,     counter_d;
    logic [6:0]        lfsr_q,        lfsr_d;
    logic [1:0]        mode_q,        mode_d;
    logic [15:0]       frame_cnt_q,   frame_cnt_d;
    logic [W-1:0]      tx_data_q,     tx_data_d;
    logic [BYTES-1:0]  tx_charisk_q,  tx_charisk_d;
    logic              frame_start_q, frame_start_d;

    logic [6:0]   prbs_state;
    logic [W-1:0] prbs_bits;
    logic         prbs_fb;
    logic [W-1:0] tbl_rdata;

    // Table write port; the payload read below sees the pre-write contents.
    always_ff @(posedge tx_clk) begin
        if (bus.tbl_we) begin
            tbl_mem_q[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

    assign tbl_rdata = tbl_mem_q[ptr_q];

    // Unrolled PRBS-7 (x^7+x^6+1): W serial steps per word, bit 0 produced first.
    always_comb begin
        prbs_state = lfsr_q;
        prbs_bits  = '0;
        prbs_fb    = 1'b0;
        for (int i = 0; i < W; i++) begin
            prbs_fb      = prbs_state[6] ^ prbs_state[5];
            prbs_bits[i] = prbs_fb;
            prbs_state   = {prbs_state[5:0], prbs_fb};
        end
    end

    // Next-state and next-output selection for the frame sequencer.
    always_comb begin
        slot_d        = slot_q;
        ptr_d         = ptr_q;
        counter_d     = counter_q;
        lfsr_d        = lfsr_q;
        mode_d        = mode_q;
        frame_cnt_d   = frame_cnt_q;
        tx_data_d     = '0;
        tx_charisk_d  = '0;
        frame_start_d = 1'b0;

        if (!bus.ready) begin
            // Link down: behave exactly like reset, table untouched.
            slot_d      = '0;
            ptr_d       = '0;
            counter_d   = '0;
            lfsr_d      = LFSR_SEED;
            mode_d      = MODE_COMMA;
            frame_cnt_d = '0;
        end else if (!bus.enable) begin
            tx_data_d    = COMMA_WORD;
            tx_charisk_d = K_ALL;
            slot_d       = '0;
        end else if (slot_q == '0) begin
            tx_data_d     = COMMA_WORD;
            tx_charisk_d  = K_ALL;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            slot_d        = SLOT_W'(1);
            mode_d        = bus.mode;
            // A new source always starts from its initial value.
            if (bus.mode != mode_q) begin
                ptr_d     = '0;
                counter_d = '0;
                lfsr_d    = LFSR_SEED;
            end
        end else begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            case (mode_q)
                MODE_TABLE: begin
                    tx_data_d = tbl_rdata;
                    ptr_d     = ptr_q + AW'(1);
                end
                MODE_COUNT: begin
                    tx_data_d = counter_q;
                    counter_d = counter_q + W'(1);
                end
                MODE_PRBS: begin
                    tx_data_d = prbs_bits;
                    lfsr_d    = prbs_state;
                end
                default: begin
                    tx_data_d    = COMMA_WORD;
                    tx_charisk_d = K_ALL;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge tx_clk) begin
        if (!reset_n) begin
            slot_q        <= '0;
            ptr_q         <= '0;
            counter_q     <= '0;
            lfsr_q        <= LFSR_SEED;
            mode_q        <= MODE_COMMA;
            frame_cnt_q   <= '0;
            tx_data_q     <= '0;
            tx_charisk_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            ptr_q         <= ptr_d;
            counter_q     <= counter_d;
            lfsr_q        <= lfsr_d;
            mode_q        <= mode_d;
            frame_cnt_q   <= frame_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_charisk_q  <= tx_charisk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_charisk  = tx_charisk_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_gt_frame_gen.sv
// Directed bench for gt_frame_gen (BYTES=2, DEPTH=8, COMMA_PERIOD=4).
module tb_gt_frame_gen;
    localparam int BYTES = 2;
    localparam int DEPTH = 8;
    localparam int CP    = 4;

    logic tx_clk  = 1'b0;
    logic reset_n = 1'b0;

    always #5 tx_clk = ~tx_clk;

    gt_frame_gen_if #(.BYTES(BYTES), .DEPTH(DEPTH)) bus ();

    gt_frame_gen #(
        .BYTES(BYTES), .DEPTH(DEPTH), .COMMA_PERIOD(CP), .K_CHAR(8'hBC)
    ) dut (
        .tx_clk (tx_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0]  m_lfsr;
    logic [15:0] w;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic exp_word(input string tag, input logic [15:0] d, input logic [1:0] k,
                            input logic fs, input logic [15:0] fc);
        tick();
        check_val({tag, ".data"}, 32'(bus.tx_data), 32'(d));
        check_val({tag, ".k"},    32'(bus.tx_charisk), 32'(k));
        check_val({tag, ".fs"},   32'(bus.frame_start), 32'(fs));
        check_val({tag, ".fc"},   32'(bus.frame_cnt), 32'(fc));
    endtask

    task automatic exp_comma(input string tag, input logic [15:0] fc);
        exp_word(tag, 16'hBCBC, 2'b11, 1'b1, fc);
    endtask

    task automatic exp_pay(input string tag, input logic [15:0] d, input logic [15:0] fc);
        exp_word(tag, d, 2'b00, 1'b0, fc);
    endtask

    // Serial PRBS-7 reference, bit 0 of the word generated first.
    task automatic prbs_next(output logic [15:0] wd);
        logic fb;
        wd = '0;
        for (int i = 0; i < 16; i++) begin
            fb     = m_lfsr[6] ^ m_lfsr[5];
            wd[i]  = fb;
            m_lfsr = {m_lfsr[5:0], fb};
        end
    endtask

    initial begin
        bus.ready     = 1'b1;
        bus.enable    = 1'b0;
        bus.mode      = 2'd0;
        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = '0;

        // reset held for three clocks
        tick();
        tick();
        exp_word("reset", 16'h0000, 2'b00, 1'b0, 16'd0);

        // idle comma stream while the table is loaded
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.tbl_we    = 1'b1;
            bus.tbl_addr  = 3'(i);
            bus.tbl_wdata = 16'h1100 + 16'(i);
            exp_word("idle", 16'hBCBC, 2'b11, 1'b0, 16'd0);
        end
        bus.tbl_we = 1'b0;

        // counter payload
        bus.enable = 1'b1;
        bus.mode   = 2'd2;
        exp_comma("cnt_c1", 16'd1);
        exp_pay("cnt", 16'h0000, 16'd1);
        exp_pay("cnt", 16'h0001, 16'd1);
        exp_pay("cnt", 16'h0002, 16'd1);
        exp_comma("cnt_c2", 16'd2);
        exp_pay("cnt", 16'h0003, 16'd2);
        exp_pay("cnt", 16'h0004, 16'd2);
        exp_pay("cnt", 16'h0005, 16'd2);

        // table payload with pointer wrap
        bus.mode = 2'd1;
        exp_comma("tbl_c3", 16'd3);
        exp_pay("tbl", 16'h1100, 16'd3);
        exp_pay("tbl", 16'h1101, 16'd3);
        exp_pay("tbl", 16'h1102, 16'd3);
        exp_comma("tbl_c4", 16'd4);
        exp_pay("tbl", 16'h1103, 16'd4);
        exp_pay("tbl", 16'h1104, 16'd4);
        exp_pay("tbl", 16'h1105, 16'd4);
        exp_comma("tbl_c5", 16'd5);
        exp_pay("tbl", 16'h1106, 16'd5);
        exp_pay("tbl", 16'h1107, 16'd5);
        exp_pay("tbl_wrap", 16'h1100, 16'd5);

        // mode change mid-frame only takes effect at the next comma
        bus.mode = 2'd2;
        exp_comma("sw_c6", 16'd6);
        exp_pay("sw_cnt", 16'h0000, 16'd6);
        bus.mode = 2'd1;
        exp_pay("sw_cnt", 16'h0001, 16'd6);
        exp_pay("sw_cnt", 16'h0002, 16'd6);
        exp_comma("sw_c7", 16'd7);
        exp_pay("sw_tbl0", 16'h1100, 16'd7);
        exp_pay("sw_tbl", 16'h1101, 16'd7);
        exp_pay("sw_tbl", 16'h1102, 16'd7);
        exp_comma("sw_c8", 16'd8);

        // read-before-write on the address being read
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = 3'd3;
        bus.tbl_wdata = 16'hAAAA;
        exp_pay("rbw_old", 16'h1103, 16'd8);
        bus.tbl_we = 1'b0;
        exp_pay("rbw", 16'h1104, 16'd8);
        exp_pay("rbw", 16'h1105, 16'd8);
        exp_comma("rbw_c9", 16'd9);
        exp_pay("rbw", 16'h1106, 16'd9);
        exp_pay("rbw", 16'h1107, 16'd9);
        exp_pay("rbw", 16'h1100, 16'd9);
        exp_comma("rbw_c10", 16'd10);
        exp_pay("rbw", 16'h1101, 16'd10);
        exp_pay("rbw", 16'h1102, 16'd10);
        exp_pay("rbw_new", 16'hAAAA, 16'd10);

        // PRBS-7 payload
        bus.mode = 2'd3;
        exp_comma("prbs_c11", 16'd11);
        m_lfsr = 7'h7F;
        prbs_next(w);
        exp_pay("prbs", w, 16'd11);
        check_val("prbs_first", 32'(bus.tx_data), 32'h0000_3040);
        prbs_next(w);
        exp_pay("prbs", w, 16'd11);
        prbs_next(w);
        exp_pay("prbs", w, 16'd11);
        exp_comma("prbs_c12", 16'd12);
        prbs_next(w);
        exp_pay("prbs", w, 16'd12);

        // ready dropped mid-frame for two clocks
        bus.ready = 1'b0;
        exp_word("rdy_low", 16'h0000, 2'b00, 1'b0, 16'd0);
        exp_word("rdy_low", 16'h0000, 2'b00, 1'b0, 16'd0);
        bus.ready = 1'b1;
        exp_comma("rdy_up", 16'd1);
        m_lfsr = 7'h7F;
        prbs_next(w);
        exp_pay("rdy_prbs", w, 16'd1);
        check_val("rdy_prbs_first", 32'(bus.tx_data), 32'h0000_3040);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
